smg_scan_disp: RTL and testbench
================================

// Module: smg_scan_disp
// PURPOSE
//  Parametrised multiplexed seven-segment scanner for the watch display path.
//  Takes the packed BCD/hex digit bus from the watch counter and drives one
//  digit at a time: one-hot digit select plus 7-segment and decimal-point lines.
//  The digit bus is captured once per frame, so a digit never tears mid-scan.
//  Adds per-digit blinking (set mode), a decimal-point mask and anti-ghost dead time.
// PARAMETERS
//  DIGITS          6      number of digits, 1..16; digit 0 = Watch_cnt_disp[3:0]
//  SCAN_DIV        50000  clk cycles per digit slot, >=2
//  BLANK_CYC       2      dead cycles at slot start with all selects off, 0..SCAN_DIV-1
//  BLINK_FRAMES    64     full frames per blink half-period, >=1
//  SEG_ACTIVE_LOW  1      1: seg_out and dp_out are inverted at the pins
//  SEL_ACTIVE_LOW  1      1: sel_out is inverted at the pins
// PORTS
//  clk             in   1          system clock; all logic on rising edge
//  rst             in   1          synchronous reset, active-high
//  Watch_cnt_disp  in   4*DIGITS   packed digit nibbles; digit k = [4k+3:4k]
//  blink_mask      in   DIGITS     1 = digit k blanks during blink-off phase
//  dp_mask         in   DIGITS     1 = light decimal point on digit k
//  seg_out         out  7          segments {g,f,e,d,c,b,a}
//  dp_out          out  1          decimal point of the active digit
//  sel_out         out  DIGITS     one-hot digit select
//  frame_start     out  1          1-cycle pulse at the start of each frame
// BEHAVIOUR
//  Reset (rst=1 at an edge): pcnt=0, idx=0, fcnt=0, blink_ph=0, snap=0;
//   seg_out/dp_out = segments off, sel_out = all inactive, frame_start=0
//   (all in pin polarity). Reset overrides all other activity, including mid-frame.
//  Counters: pcnt counts 0..SCAN_DIV-1 and wraps.
//   - When pcnt==SCAN_DIV-1, idx advances; it wraps from DIGITS-1 to 0.
//   - Frame end is pcnt==SCAN_DIV-1 && idx==DIGITS-1.
//  Snapshot: at frame end, snap<=Watch_cnt_disp.
//   - The first frame after reset displays all-zero digits.
//   - Bus changes during a frame are not shown until the next frame.
//  Blink: at frame end, fcnt increments. When fcnt==BLINK_FRAMES-1, fcnt wraps to 0
//   and blink_ph toggles. blink_mask and dp_mask are sampled live, not snapshotted.
//  Outputs are registered, 1 cycle after the (pcnt, idx) state they reflect:
//   - sel_out: all off if pcnt<BLANK_CYC, else onehot(idx).
//   - seg_out: decode(snap nibble idx), or all off if blink_mask[idx] && blink_ph.
//   - dp_out: dp_mask[idx], gated by the same blink blanking.
//   - frame_start: 1 in the cycle after the state pcnt==0 && idx==0.
//     It is also asserted for the first frame after reset.
//  Decode (active-high, hex {g..a}):
//   - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//   - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  Polarity: the XOR with SEG_ACTIVE_LOW / SEL_ACTIVE_LOW is applied last,
//   after the output register. Reset values use the same polarity.
//  DIGITS=1: idx stays 0, and every slot end is also a frame end.
// TESTING (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, active-low both)
//  1. Reset: rst=1 for 3 cycles -> seg_out=7F, dp_out=1, sel_out=F, frame_start=0;
//     release -> first frame shows digit "0" (seg_out=40) on sels E,D,B,7.
//  2. Scan timing: bus=16'h4321 loaded at frame end -> next frame, per 4-cycle slot,
//     sel_out=F for 1 cycle, then digit 0 sel=E seg=~06=79, 1 sel=D seg=24,
//     2 sel=B seg=30, 3 sel=7 seg=19.
//  3. Tear-free: change bus to 16'h9999 mid-frame -> current frame still shows 4321;
//     the following frame shows 9 (seg=10) on all digits.
//  4. Blink: blink_mask=4'b0001 -> digit 0 shows 2 frames, then blank (seg=7F, dp=1)
//     for 2 frames, repeating; other digits are unaffected.
//  5. DP and hex: dp_mask=4'b0100, bus=16'hFEDC -> dp_out=0 only in digit-2 slots;
//     seg = ~39, ~5E, ~79, ~71.
//  6. Reset mid-frame: assert rst while idx=2, pcnt=3 -> next cycle all reset values;
//     the scan restarts at digit 0 with frame_start and the snapshot cleared to 0.

Source files
------------

// File: rtl/smg_scan_disp.sv
// Multiplexed seven-segment scanner: one digit per slot, frame-captured digit bus,
// per-digit blink blanking, decimal-point mask and anti-ghost dead time.
module smg_scan_disp #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 2,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   Watch_cnt_disp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_start
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SW = 4 * DIGITS;

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  logic [PW-1:0]     pcnt, pcnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [FW-1:0]     fcnt, fcnt_n;
  logic              blink_ph, blink_ph_n;
  logic [SW-1:0]     snap, snap_n;
  logic [6:0]        seg_q, seg_n;
  logic              dp_q, dp_n;
  logic [DIGITS-1:0] sel_q, sel_n;
  logic              fs_q, fs_n;

  logic              slot_end, frame_end, blank, blink_k, dp_k;
  logic [3:0]        nib;
  logic [DIGITS-1:0] onehot;

  // Active-high {g,f,e,d,c,b,a} hex font
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    pcnt_n     = pcnt;
    idx_n      = idx;
    fcnt_n     = fcnt;
    blink_ph_n = blink_ph;
    snap_n     = snap;
    nib        = 4'h0;
    blink_k    = 1'b0;
    dp_k       = 1'b0;
    onehot     = '0;

    slot_end  = (pcnt == PW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx == IW'(DIGITS - 1));

    if (slot_end) begin
      pcnt_n = '0;
      idx_n  = frame_end ? '0 : idx + IW'(1);
    end else begin
      pcnt_n = pcnt + PW'(1);
    end

    // Frame boundary: capture the digit bus and advance the blink frame counter
    if (frame_end) begin
      snap_n = Watch_cnt_disp;
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_n     = '0;
        blink_ph_n = ~blink_ph;
      end else begin
        fcnt_n = fcnt + FW'(1);
      end
    end

    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == IW'(k)) begin
        nib       = snap[4*k +: 4];
        blink_k   = blink_mask[k];
        dp_k      = dp_mask[k];
        onehot[k] = 1'b1;
      end
    end

    blank = blink_k && blink_ph;
    seg_n = blank ? 7'h00 : dec7(nib);
    dp_n  = dp_k && !blank;
    sel_n = (pcnt < PW'(BLANK_CYC)) ? '0 : onehot;
    fs_n  = (pcnt == '0) && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt     <= '0;
      idx      <= '0;
      fcnt     <= '0;
      blink_ph <= 1'b0;
      snap     <= '0;
      seg_q    <= 7'h00;
      dp_q     <= 1'b0;
      sel_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      pcnt     <= pcnt_n;
      idx      <= idx_n;
      fcnt     <= fcnt_n;
      blink_ph <= blink_ph_n;
      snap     <= snap_n;
      seg_q    <= seg_n;
      dp_q     <= dp_n;
      sel_q    <= sel_n;
      fs_q     <= fs_n;
    end
  end

  // Pin polarity applied after the output registers
  assign seg_out     = seg_q ^ {7{SEG_INV}};
  assign dp_out      = dp_q ^ SEG_INV;
  assign sel_out     = sel_q ^ {DIGITS{SEL_INV}};
  assign frame_start = fs_q;

endmodule

// File: tb/tb_smg_scan_disp.sv
// Bench for smg_scan_disp: a time-indexed reference model predicts every output pin
// cycle by cycle; directed scenarios add literal display checks.
module tb_smg_scan_disp;

  localparam int unsigned DG = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned BL = 1;
  localparam int unsigned BF = 2;
  localparam int unsigned FL = SD * DG;

  logic        clk;
  logic        rst;
  logic [15:0] bus;
  logic [3:0]  bmask;
  logic [3:0]  dmask;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  sel_out;
  logic        frame_start;

  int total;
  int bad;

  // Model: t counts cycles since reset release; everything else derives from it
  int unsigned t;
  logic [15:0] snap_m;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_sel;
  logic        exp_fs;
  logic [6:0]  font [16];

  smg_scan_disp #(
    .DIGITS(DG), .SCAN_DIV(SD), .BLANK_CYC(BL), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .Watch_cnt_disp(bus), .blink_mask(bmask),
    .dp_mask(dmask), .seg_out(seg_out), .dp_out(dp_out), .sel_out(sel_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic int unsigned cur_idx();
    return (t / SD) % DG;
  endfunction

  task automatic model_reset();
    t      = 0;
    snap_m = 16'h0000;
  endtask

  // Expected pins for the edge that samples state t
  task automatic predict();
    int unsigned p, ix, fr;
    logic        blank;
    logic [3:0]  nib;
    p     = t % SD;
    ix    = cur_idx();
    fr    = t / FL;
    nib   = 4'((snap_m >> (4 * ix)) & 16'h000F);
    blank = bmask[ix] && (((fr / BF) % 2) == 1);
    exp_seg = blank ? 7'h7F : ~font[nib];
    exp_dp  = blank ? 1'b1 : ~dmask[ix];
    exp_sel = (p < BL) ? 4'hF : ~(4'(1) << ix);
    exp_fs  = (p == 0) && (ix == 0);
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    if ((t % SD) == SD - 1 && cur_idx() == DG - 1) snap_m = bus;
    t++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
        bad++;
        $display("FAIL reset_hold c=%0d got seg=%h dp=%b sel=%h fs=%b need seg=7f dp=1 sel=f fs=0",
                 c, seg_out, dp_out, sel_out, frame_start);
      end
    end
    rst = 1'b0;
    bus = 16'h4321;
    model_reset();
    for (int c = 0; c < int'(FL); c++) begin
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL first_frame t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      if (sel_out !== 4'hF) begin
        total++;
        if (seg_out !== 7'h40) begin
          bad++;
          $display("FAIL first_frame_zero t=%0d got seg=%h need 40", t, seg_out);
        end
      end
      advance();
    end
  endtask

  task automatic test_scan();
    logic [6:0]  lit [4];
    int unsigned ix;
    lit = '{7'h79, 7'h24, 7'h30, 7'h19};
    for (int c = 0; c < int'(FL); c++) begin
      ix = cur_idx();
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL scan t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      if (sel_out !== 4'hF) begin
        total++;
        if (seg_out !== lit[ix]) begin
          bad++;
          $display("FAIL scan_4321 digit=%0d got seg=%h need %h", ix, seg_out, lit[ix]);
        end
      end
      advance();
    end
  endtask

  task automatic test_tear_free();
    int unsigned fr;
    for (int c = 0; c < int'(2 * FL); c++) begin
      if (c == 5) bus = 16'h9999;
      fr = t / FL;
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL tear t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      if (sel_out !== 4'hF && c >= int'(FL)) begin
        total++;
        if (seg_out !== 7'h10) begin
          bad++;
          $display("FAIL tear_nines frame=%0d got seg=%h need 10", fr, seg_out);
        end
      end
      advance();
    end
    // Bus churning every cycle must only appear at frame granularity
    for (int c = 0; c < int'(3 * FL); c++) begin
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL tear_churn t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      advance();
      bus = 16'($urandom);
    end
  endtask

  task automatic test_blink();
    int blanks;
    bmask  = 4'b0001;
    bus    = 16'($urandom);
    blanks = 0;
    for (int c = 0; c < int'(8 * FL); c++) begin
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL blink t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      if (sel_out == 4'hE && seg_out == 7'h7F) blanks++;
      advance();
    end
    // 8 frames at 2-frame half period: 4 blanked frames x 3 selected cycles of digit 0
    total++;
    if (blanks != 12) begin
      bad++;
      $display("FAIL blink_count got %0d blanked digit0 cycles need 12", blanks);
    end
    bmask = 4'b0000;
  endtask

  task automatic test_dp_hex();
    logic [6:0]  lit [4];
    int unsigned ix;
    lit   = '{7'h46, 7'h21, 7'h06, 7'h0E};
    dmask = 4'b0100;
    bus   = 16'hFEDC;
    for (int c = 0; c < int'(2 * FL); c++) begin
      if ((t % FL) == 0 && c > 0 && c < int'(FL)) break;
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL dp_align t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      advance();
    end
    for (int c = 0; c < int'(FL); c++) begin
      ix = cur_idx();
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL dp_hex t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      if (sel_out !== 4'hF) begin
        total++;
        if (seg_out !== lit[ix] || dp_out !== (ix != 2)) begin
          bad++;
          $display("FAIL dp_hex_lit digit=%0d got seg=%h dp=%b need seg=%h dp=%b",
                   ix, seg_out, dp_out, lit[ix], (ix != 2));
        end
      end
      advance();
    end
    dmask = 4'b0000;
  endtask

  task automatic test_random();
    for (int c = 0; c < int'(12 * FL); c++) begin
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL random t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      advance();
      bus = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bmask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dmask = 4'($urandom);
    end
  endtask

  task automatic test_reset_mid_frame();
    bmask = 4'b1111;
    for (int c = 0; c < int'(FL); c++) begin
      if ((t % SD) == 3 && cur_idx() == 2) break;
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL mid_approach t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      advance();
    end
    bmask = 4'b0000;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({seg_out, dp_out, sel_out, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got seg=%h dp=%b sel=%h fs=%b need seg=7f dp=1 sel=f fs=0",
               seg_out, dp_out, sel_out, frame_start);
    end
    rst = 1'b0;
    bus = 16'($urandom);
    model_reset();
    for (int c = 0; c < int'(2 * FL); c++) begin
      cycle();
      total++;
      if ({seg_out, dp_out, sel_out, frame_start} !== {exp_seg, exp_dp, exp_sel, exp_fs}) begin
        bad++;
        $display("FAIL mid_restart t=%0d got %h/%b/%h/%b need %h/%b/%h/%b", t,
                 seg_out, dp_out, sel_out, frame_start, exp_seg, exp_dp, exp_sel, exp_fs);
      end
      if (c == 0) begin
        total++;
        if (frame_start !== 1'b1 || sel_out !== 4'hF) begin
          bad++;
          $display("FAIL mid_restart_fs got fs=%b sel=%h need fs=1 sel=f", frame_start, sel_out);
        end
      end
      if (c < int'(FL) && sel_out !== 4'hF) begin
        total++;
        if (seg_out !== 7'h40) begin
          bad++;
          $display("FAIL mid_restart_zero t=%0d got seg=%h need 40", t, seg_out);
        end
      end
      advance();
    end
  endtask

  initial begin
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    clk   = 1'b0;
    rst   = 1'b1;
    bus   = 16'h0000;
    bmask = 4'b0000;
    dmask = 4'b0000;
    total = 0;
    bad   = 0;
    model_reset();

    test_reset();
    test_scan();
    test_tear_free();
    test_blink();
    test_dp_hex();
    test_random();
    test_reset_mid_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
